// File: rtl/lfsr_pkg.sv
// Shared types and the Galois LFSR step function for the lfsr_stream block.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The step works at a fixed maximum width.
  // Zero-extended callers take back their low bits, which is exact for a right shift.
  localparam int LFSR_MAX_W = 64;

  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] tap
  );
    return (s >> 1) ^ (s[0] ? tap : '0);
  endfunction

endpackage

// File: rtl/lfsr_stream.sv
// Galois LFSR word streamer: accepts tap/seed/length, emits cfg_len words with
// valid/ready flow control, then pulses done. Zero seeds are rejected in LOAD.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_tap,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             seed_err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr_q, tap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seed_err_q, seed_err_nxt;
  logic             cfg_hs, out_hs;

  assign cfg_ready = (state == IDLE);
  assign out_valid = (state == RUN);
  assign out_data  = lfsr_q;
  assign busy      = (state == LOAD) || (state == RUN);
  assign done      = (state == DONE);
  assign seed_err  = seed_err_q;

  assign cfg_hs = cfg_valid && cfg_ready;
  // A word handshake cancelled by abort must not advance the LFSR.
  assign out_hs = out_valid && out_ready && !abort;

  always_comb begin
    state_nxt    = state;
    seed_err_nxt = 1'b0;
    case (state)
      IDLE: if (cfg_valid) state_nxt = LOAD;
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (lfsr_q == '0) begin
          state_nxt    = IDLE;
          seed_err_nxt = 1'b1;
        end else if (cnt_q == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) state_nxt = IDLE;
        else if (out_ready && cnt_q == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr_q     <= '0;
      tap_q      <= '0;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      seed_err_q <= seed_err_nxt;
      if (cfg_hs) begin
        tap_q  <= cfg_tap;
        lfsr_q <= cfg_seed;
        cnt_q  <= cfg_len;
      end else if (out_hs) begin
        lfsr_q <= WIDTH'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(tap_q)));
        cnt_q  <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: hand-computed vectors for the normal run,
// stalls, zero seed, zero length, abort and asynchronous reset.
module tb_lfsr_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid, cfg_ready;
  logic [WIDTH-1:0] cfg_tap, cfg_seed;
  logic [CNT_W-1:0] cfg_len;
  logic             abort;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy, done, seed_err;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [WIDTH-1:0] TAP = 32'hB4BC_D35C;
  logic [WIDTH-1:0] exp_w [3];

  lfsr_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tap(cfg_tap), .cfg_seed(cfg_seed), .cfg_len(cfg_len),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .seed_err(seed_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a configuration for one cycle; returns in the LOAD cycle.
  task automatic cfg(input logic [WIDTH-1:0] tap, input logic [WIDTH-1:0] seed,
                     input logic [CNT_W-1:0] len);
    cfg_tap = tap; cfg_seed = seed; cfg_len = len; cfg_valid = 1'b1;
    chk("cfg_ready_idle", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_no_valid", out_valid, 0);
  endtask

  // tap=B4BCD35C seed=1 len=3, out_ready held high.
  task automatic run_basic(input string tag);
    out_ready = 1'b1;
    cfg(TAP, 32'h1, 16'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, exp_w[i]);
      chk({tag, "_nodone"}, done, 0);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_valid_off"}, out_valid, 0);
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready_back"}, cfg_ready, 1);
  endtask

  initial begin
    int           acc;
    logic [3:0]   pat;
    exp_w[0] = 32'h0000_0001;
    exp_w[1] = 32'hB4BC_D35C;
    exp_w[2] = 32'h5A5E_69AE;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_tap = '0; cfg_seed = '0; cfg_len = '0;
    abort = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seed_err", seed_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_basic("basic");

    // Zero seed is rejected two cycles after the handshake.
    cfg(TAP, 32'h0, 16'd5);
    step();
    chk("zseed_err", seed_err, 1);
    chk("zseed_valid", out_valid, 0);
    chk("zseed_ready", cfg_ready, 1);
    step();
    chk("zseed_err_pulse", seed_err, 0);
    chk("zseed_valid2", out_valid, 0);

    // Zero length, with abort held high in IDLE and DONE (must be ignored there).
    abort = 1'b1;
    cfg_tap = TAP; cfg_seed = 32'h1; cfg_len = '0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    abort = 1'b0;
    chk("zlen_load", busy, 1);
    step();
    abort = 1'b1;
    chk("zlen_done", done, 1);
    chk("zlen_valid", out_valid, 0);
    step();
    abort = 1'b0;
    chk("zlen_done_pulse", done, 0);
    chk("zlen_idle", cfg_ready, 1);

    // Stall pattern 1,0,0,1,1: data holds while out_ready is low.
    cfg(TAP, 32'h1, 16'd3);
    step();
    acc = 0;
    pat = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      out_ready = (c < 4) ? !pat[c] : 1'b1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp_w[acc]);
      if (out_ready) acc++;
      step();
    end
    chk("stall_count", acc, 3);
    chk("stall_done", done, 1);
    step();

    // Abort after the first accepted word of a len=10 run.
    out_ready = 1'b1;
    cfg(TAP, 32'h1, 16'd10);
    step();
    chk("abort_w0", out_data, exp_w[0]);
    step();
    abort = 1'b1;
    chk("abort_w1", out_data, exp_w[1]);
    step();
    abort = 1'b0;
    chk("abort_idle", cfg_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_nodone", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_held", out_data, exp_w[1]);
    run_basic("post_abort");

    // Maximum length starts and keeps streaming; then aborted.
    cfg(TAP, 32'h1, 16'hFFFF);
    for (int i = 0; i < 6; i++) step();
    chk("maxlen_busy", busy, 1);
    chk("maxlen_valid", out_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("maxlen_abort", cfg_ready, 1);

    // Asynchronous reset mid-run.
    cfg(TAP, 32'h1, 16'd3);
    step();
    chk("mid_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_nodone", done, 0);
    run_basic("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
